// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: CPU-side signal bundle of the interrupt controller.
// master = control unit / datapath side, slave = the controller itself.
//
// Handshake semantics: there is no valid/ready pair on this bundle.
// - irq_ext, timer_tick, reti and ien_we are single-cycle or level events
//   sampled on the rising clock edge.
// - s_intr1/s_intr2/push_req are one-cycle pulses, one pulse per accepted
//   interrupt.
// - Status outputs are registered and change only on a rising clock edge.
interface intr_ctrl_if;
  logic       irq_ext;
  logic       timer_tick;
  logic       reti;
  logic       hold;
  logic       ien_we;
  logic [1:0] ien_wd;
  logic       s_intr1;
  logic       s_intr2;
  logic       push_req;
  logic       in_service;
  logic [1:0] active_src;
  logic [1:0] pending;
  logic [1:0] overrun;
  logic [1:0] state_dbg;

  modport master (
    output irq_ext, timer_tick, reti, hold, ien_we, ien_wd,
    input  s_intr1, s_intr2, push_req, in_service, active_src, pending,
           overrun, state_dbg
  );

  modport slave (
    input  irq_ext, timer_tick, reti, hold, ien_we, ien_wd,
    output s_intr1, s_intr2, push_req, in_service, active_src, pending,
           overrun, state_dbg
  );
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl: two-source interrupt controller for the single-cycle CPU.
// src1 = external request (irq_ext, synchronised, rising edge, high priority)
// src2 = timer tick (one-cycle pulse, low priority).
// Sequences entry (one vector pulse), service and return via reti, with a
// short guard window after the final reti during which no entry is taken.
// Optional feature macro: INTR_NEST_EN lets src1 preempt a src2 service
// (nesting depth 2). Without it the depth never exceeds 1.
module intr_ctrl #(
  parameter int SYNC_STAGES = 2,  // 2..4 synchroniser flops on irq_ext
  parameter int RETI_GUARD  = 1   // 0..15 blocked cycles after final reti
) (
  input logic        clk,
  input logic        reset,
  intr_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTER   = 2'd1,
    SERVICE = 2'd2,
    GUARD   = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   irq_prev;
  logic [1:0]             evt;
  logic [1:0]             pending;
  logic [1:0]             overrun;
  logic [1:0]             ien;
  logic [1:0]             elig;
  logic [1:0]             win;
  logic [1:0]             take;
  logic [1:0]             active, active_nxt;
  logic [1:0]             depth, depth_nxt;
  logic [3:0]             guard_cnt, guard_nxt;

  // Synchronise irq_ext and remember the previous synchronised level
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q   <= '0;
      irq_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.irq_ext};
      irq_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  // src1 event is a rising edge of the synchronised pin; src2 is the raw tick
  assign evt[0] = sync_q[SYNC_STAGES-1] & ~irq_prev;
  assign evt[1] = bus.timer_tick;

  assign elig = pending & ien;
  // src1 always wins a tie
  assign win  = elig[0] ? 2'b01 : 2'b10;

  // Enable mask and sticky overrun flags; an ien write clears overrun
  always_ff @(posedge clk) begin
    if (!reset) begin
      ien     <= 2'b00;
      overrun <= 2'b00;
    end else if (bus.ien_we) begin
      ien     <= bus.ien_wd;
      overrun <= 2'b00;
    end else begin
      overrun <= overrun | (evt & pending);
    end
  end

  // Pending latch: a same-cycle event beats the clear from entry
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= 2'b00;
    end else begin
      pending <= (pending & ~take) | evt;
    end
  end

  // FSM next-state, entry selection, depth and guard bookkeeping
  always_comb begin
    state_nxt  = state;
    active_nxt = active;
    depth_nxt  = depth;
    guard_nxt  = guard_cnt;
    take       = 2'b00;
    case (state)
      IDLE: begin
        if ((|elig) && !bus.hold) begin
          state_nxt  = ENTER;
          take       = win;
          active_nxt = win;
        end
      end
      ENTER: begin
        // reti is ignored here; entry always completes in one cycle
        state_nxt = SERVICE;
        depth_nxt = depth + 2'd1;
      end
      SERVICE: begin
        if (bus.reti && (depth == 2'd1)) begin
          active_nxt = 2'b00;
          depth_nxt  = 2'd0;
          if (RETI_GUARD > 0) begin
            state_nxt = GUARD;
            guard_nxt = 4'(RETI_GUARD - 1);
          end else begin
            state_nxt = IDLE;
          end
        end
`ifdef INTR_NEST_EN
        else if (bus.reti && (depth == 2'd2)) begin
          // returning from the nested src1 handler back into src2
          depth_nxt  = 2'd1;
          active_nxt = 2'b10;
        end else if ((active == 2'b10) && (depth == 2'd1) && elig[0] && !bus.hold) begin
          // only src1 may preempt, and only a src2 service at depth 1
          state_nxt  = ENTER;
          take       = 2'b01;
          active_nxt = 2'b01;
        end
`endif
      end
      GUARD: begin
        // eligibility and reti are both ignored while the guard runs
        if (guard_cnt == 4'd0) begin
          state_nxt = IDLE;
        end else begin
          guard_nxt = guard_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register and its companion bookkeeping registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      active    <= 2'b00;
      depth     <= 2'd0;
      guard_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      active    <= active_nxt;
      depth     <= depth_nxt;
      guard_cnt <= guard_nxt;
    end
  end

  // Outputs decode registered state only, so the vector pulse is glitch-free
  // and lasts exactly the single ENTER cycle.
  assign bus.s_intr1    = (state == ENTER) && (active == 2'b01);
  assign bus.s_intr2    = (state == ENTER) && (active == 2'b10);
  assign bus.push_req   = bus.s_intr1 | bus.s_intr2;
  assign bus.in_service = (state == ENTER) || (state == SERVICE);
  assign bus.active_src = active;
  assign bus.pending    = pending;
  assign bus.overrun    = overrun;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed self-checking bench for intr_ctrl (default
// parameters SYNC_STAGES=2, RETI_GUARD=1). Observed vector layout:
// {s_intr1, s_intr2, push_req, in_service}_{active_src}_{pending}_{overrun}_{state}
// state: 00 IDLE, 01 ENTER, 10 SERVICE, 11 GUARD.
module tb_intr_ctrl;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [11:0] exp_v;

  intr_ctrl_if bus ();

  intr_ctrl #(.SYNC_STAGES(2), .RETI_GUARD(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wire [11:0] outs = {bus.s_intr1, bus.s_intr2, bus.push_req, bus.in_service,
                      bus.active_src, bus.pending, bus.overrun, bus.state_dbg};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ien(input logic [1:0] v);
    bus.ien_we = 1'b1;
    bus.ien_wd = v;
    step();
    bus.ien_we = 1'b0;
    bus.ien_wd = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    exp_v = 12'b0000_00_00_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL reset_outs got=%b exp=%b", outs, exp_v); end
    reset = 1'b1;
    step();
    exp_v = 12'b0000_00_00_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL reset_release got=%b exp=%b", outs, exp_v); end
  endtask

  // Scenario 1: timer entry, service, reti, guard, idle
  task automatic test_timer();
    write_ien(2'b10);
    bus.timer_tick = 1'b1;
    step();
    bus.timer_tick = 1'b0;
    exp_v = 12'b0000_00_10_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t1_pending got=%b exp=%b", outs, exp_v); end
    step();
    exp_v = 12'b0111_10_00_00_01; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t1_enter got=%b exp=%b", outs, exp_v); end
    step();
    exp_v = 12'b0001_10_00_00_10; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t1_service got=%b exp=%b", outs, exp_v); end
    step();
    step();
    exp_v = 12'b0001_10_00_00_10; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t1_service_hold got=%b exp=%b", outs, exp_v); end
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    exp_v = 12'b0000_00_00_00_11; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t1_guard got=%b exp=%b", outs, exp_v); end
    step();
    exp_v = 12'b0000_00_00_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t1_idle got=%b exp=%b", outs, exp_v); end
  endtask

  // Scenario 2: src1 and src2 become pending together; src1 goes first
  task automatic test_priority();
    write_ien(2'b11);
    bus.irq_ext = 1'b1;
    step();
    step();
    // src1 edge is detected on the next edge; line the tick up with it
    bus.timer_tick = 1'b1;
    step();
    bus.timer_tick = 1'b0;
    exp_v = 12'b0000_00_11_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t2_both_pending got=%b exp=%b", outs, exp_v); end
    step();
    exp_v = 12'b1011_01_10_00_01; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t2_enter_src1 got=%b exp=%b", outs, exp_v); end
    step();
    exp_v = 12'b0001_01_10_00_10; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t2_service_src1 got=%b exp=%b", outs, exp_v); end
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    exp_v = 12'b0000_00_10_00_11; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t2_guard got=%b exp=%b", outs, exp_v); end
    step();
    exp_v = 12'b0000_00_10_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t2_idle_after_guard got=%b exp=%b", outs, exp_v); end
    step();
    exp_v = 12'b0111_10_00_00_01; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t2_enter_src2 got=%b exp=%b", outs, exp_v); end
    step();
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    step();
    exp_v = 12'b0000_00_00_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t2_final got=%b exp=%b", outs, exp_v); end
    bus.irq_ext = 1'b0;
    step();
    step();
    step();
    exp_v = 12'b0000_00_00_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t2_fall_no_event got=%b exp=%b", outs, exp_v); end
  endtask

  // Scenario 3: masked tick stays pending, enabling it triggers entry
  task automatic test_mask();
    write_ien(2'b00);
    bus.timer_tick = 1'b1;
    step();
    bus.timer_tick = 1'b0;
    step();
    step();
    step();
    exp_v = 12'b0000_00_10_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t3_masked got=%b exp=%b", outs, exp_v); end
    write_ien(2'b10);
    exp_v = 12'b0000_00_10_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t3_write_edge got=%b exp=%b", outs, exp_v); end
    step();
    exp_v = 12'b0111_10_00_00_01; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t3_enter got=%b exp=%b", outs, exp_v); end
    step();
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    step();
    exp_v = 12'b0000_00_00_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t3_idle got=%b exp=%b", outs, exp_v); end
  endtask

  // Scenario 4: hold blocks entry; a second tick while pending sets overrun
  task automatic test_hold_overrun();
    bus.hold = 1'b1;
    bus.timer_tick = 1'b1;
    step();
    bus.timer_tick = 1'b0;
    step();
    exp_v = 12'b0000_00_10_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t4_held got=%b exp=%b", outs, exp_v); end
    bus.timer_tick = 1'b1;
    step();
    bus.timer_tick = 1'b0;
    exp_v = 12'b0000_00_10_10_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t4_overrun got=%b exp=%b", outs, exp_v); end
    step();
    step();
    exp_v = 12'b0000_00_10_10_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t4_still_held got=%b exp=%b", outs, exp_v); end
    bus.hold = 1'b0;
    step();
    exp_v = 12'b0111_10_00_10_01; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t4_enter got=%b exp=%b", outs, exp_v); end
    step();
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    step();
    exp_v = 12'b0000_00_00_10_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t4_sticky got=%b exp=%b", outs, exp_v); end
    write_ien(2'b10);
    exp_v = 12'b0000_00_00_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t4_ovr_clear got=%b exp=%b", outs, exp_v); end
  endtask

  // reti outside SERVICE has no effect
  task automatic test_reti_ignored();
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    exp_v = 12'b0000_00_00_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL reti_idle got=%b exp=%b", outs, exp_v); end
    bus.timer_tick = 1'b1;
    step();
    bus.timer_tick = 1'b0;
    step();
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    exp_v = 12'b0001_10_00_00_10; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL reti_enter got=%b exp=%b", outs, exp_v); end
    bus.reti = 1'b1;
    step();
    exp_v = 12'b0000_00_00_00_11; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL reti_to_guard got=%b exp=%b", outs, exp_v); end
    step();
    bus.reti = 1'b0;
    exp_v = 12'b0000_00_00_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL reti_guard got=%b exp=%b", outs, exp_v); end
  endtask

`ifdef INTR_NEST_EN
  // Scenario 5: src1 preempts a src2 service
  task automatic test_nesting();
    write_ien(2'b11);
    bus.timer_tick = 1'b1;
    step();
    bus.timer_tick = 1'b0;
    step();
    step();
    bus.irq_ext = 1'b1;
    step();
    step();
    step();
    exp_v = 12'b0001_10_01_00_10; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t5_pend_src1 got=%b exp=%b", outs, exp_v); end
    step();
    exp_v = 12'b1011_01_00_00_01; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t5_nest_enter got=%b exp=%b", outs, exp_v); end
    step();
    exp_v = 12'b0001_01_00_00_10; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t5_nest_service got=%b exp=%b", outs, exp_v); end
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    exp_v = 12'b0001_10_00_00_10; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t5_inner_reti got=%b exp=%b", outs, exp_v); end
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    exp_v = 12'b0000_00_00_00_11; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t5_outer_reti got=%b exp=%b", outs, exp_v); end
    step();
    exp_v = 12'b0000_00_00_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t5_idle got=%b exp=%b", outs, exp_v); end
    bus.irq_ext = 1'b0;
    step();
    step();
    step();
  endtask
`else
  // Without nesting, src1 waits for the src2 service to finish
  task automatic test_nesting();
    write_ien(2'b11);
    bus.timer_tick = 1'b1;
    step();
    bus.timer_tick = 1'b0;
    step();
    step();
    bus.irq_ext = 1'b1;
    step();
    step();
    step();
    exp_v = 12'b0001_10_01_00_10; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t5_pend_src1 got=%b exp=%b", outs, exp_v); end
    step();
    exp_v = 12'b0001_10_01_00_10; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t5_no_preempt got=%b exp=%b", outs, exp_v); end
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    exp_v = 12'b0000_00_01_00_11; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t5_guard got=%b exp=%b", outs, exp_v); end
    step();
    step();
    exp_v = 12'b1011_01_00_00_01; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t5_enter_src1 got=%b exp=%b", outs, exp_v); end
    step();
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    step();
    exp_v = 12'b0000_00_00_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t5_idle got=%b exp=%b", outs, exp_v); end
    bus.irq_ext = 1'b0;
    step();
    step();
    step();
  endtask
`endif

  // Scenario 6: reset during SERVICE, later reti ignored, ien cleared
  task automatic test_reset_mid_service();
    write_ien(2'b10);
    bus.timer_tick = 1'b1;
    step();
    bus.timer_tick = 1'b0;
    step();
    step();
    exp_v = 12'b0001_10_00_00_10; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t6_service got=%b exp=%b", outs, exp_v); end
    reset = 1'b0;
    step();
    exp_v = 12'b0000_00_00_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t6_reset got=%b exp=%b", outs, exp_v); end
    reset = 1'b1;
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;
    exp_v = 12'b0000_00_00_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t6_reti_after got=%b exp=%b", outs, exp_v); end
    bus.timer_tick = 1'b1;
    step();
    bus.timer_tick = 1'b0;
    step();
    exp_v = 12'b0000_00_10_00_00; n_checks++; if (outs !== exp_v) begin n_fail++; $display("FAIL t6_ien_cleared got=%b exp=%b", outs, exp_v); end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b0;
    bus.irq_ext    = 1'b0;
    bus.timer_tick = 1'b0;
    bus.reti       = 1'b0;
    bus.hold       = 1'b0;
    bus.ien_we     = 1'b0;
    bus.ien_wd     = 2'b00;
    #1;
    test_reset();
    test_timer();
    test_priority();
    test_mask();
    test_hold_overrun();
    test_reti_ignored();
    test_nesting();
    test_reset_mid_service();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
